// File: rtl/scaler_chan_reader.sv
// scaler_chan_reader
// Reads the 28-bit scaler count through its two 14-bit readout gates
// (RCHBT_ -> CHBT high half, RCHAT_ -> CHAT low half) using a
// high-low-high sequence. A re-read is issued when the two high-half samples
// differ, so a carry between the halves never produces a torn value.
// Optional build macro: SCALER_READ_DELTA_EN adds DELTA / DELTA_OK outputs
// carrying the modulo-2^28 difference between consecutive coherent reads.
module scaler_chan_reader #(
  parameter int SETTLE    = 4,  // strobe-low cycles before sampling, 1..15
  parameter int MAX_RETRY = 3   // re-reads after a high-half mismatch, 1..7
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        REQ,
  output logic        RCHAT_,
  output logic        RCHBT_,
  input  logic [13:0] CHAT,
  input  logic [13:0] CHBT,
  output logic [27:0] VALUE,
  output logic        VALID,
  output logic        BUSY,
  output logic        ERR
`ifdef SCALER_READ_DELTA_EN
  ,
  output logic [27:0] DELTA,
  output logic        DELTA_OK
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_H1,
    S_GAP1,
    S_RD_L,
    S_GAP2,
    S_RD_H2,
    S_CHECK,
    S_DONE
  } state_e;

  // RD_H1 is entered straight from IDLE, so its first cycle launches the
  // registered strobe; the window therefore ends one count later there.
  localparam logic [3:0] CNT_LAST    = 4'(SETTLE - 1);
  localparam logic [3:0] CNT_LAST_H1 = 4'(SETTLE);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  retry_q, retry_d;
  logic [13:0] h1_q, h1_d;
  logic [13:0] l_q, l_d;
  logic [13:0] h2_q, h2_d;
  logic [27:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        rchat_q, rchat_d;
  logic        rchbt_q, rchbt_d;

  logic win_done;
  logic halves_match;
  logic may_retry;

  assign win_done     = (state_q == S_RD_H1) ? (cnt_q == CNT_LAST_H1) : (cnt_q == CNT_LAST);
  assign halves_match = (h1_q == h2_q);
  assign may_retry    = (retry_q < RETRY_MAX);

  // State register.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (!SIM_RST) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic for the high-low-high read sequence.
  always_comb begin
    // NOTE: every combinational output is given a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (REQ) state_d = S_RD_H1;
      S_RD_H1: if (win_done) state_d = S_GAP1;
      S_GAP1:  state_d = S_RD_L;
      S_RD_L:  if (win_done) state_d = S_GAP2;
      S_GAP2:  state_d = S_RD_H2;
      S_RD_H2: if (win_done) state_d = S_CHECK;
      S_CHECK: state_d = (halves_match || !may_retry) ? S_DONE : S_GAP1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state so they align with it.
  always_comb begin
    rchbt_d = 1'b1;
    rchat_d = 1'b1;
    if ((state_d == S_RD_H1 && state_q == S_RD_H1) || state_d == S_RD_H2) rchbt_d = 1'b0;
    if (state_d == S_RD_L) rchat_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  // Window counter, half captures, retry bookkeeping and result update.
  always_comb begin
    cnt_d   = 4'd0;
    h1_d    = h1_q;
    l_d     = l_q;
    h2_d    = h2_q;
    retry_d = retry_q;
    err_d   = err_q;
    value_d = value_q;
    if (state_d == state_q && (state_q inside {S_RD_H1, S_RD_L, S_RD_H2}))
      cnt_d = cnt_q + 4'd1;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          retry_d = 3'd0;
          err_d   = 1'b0;
        end
      end
      S_RD_H1: if (win_done) h1_d = CHBT;
      S_RD_L:  if (win_done) l_d  = CHAT;
      S_RD_H2: if (win_done) h2_d = CHBT;
      S_CHECK: begin
        if (halves_match) begin
          value_d = {h1_q, l_q};
        end else if (may_retry) begin
          // The newer high half becomes the reference for the re-read.
          retry_d = retry_q + 3'd1;
          h1_d    = h2_q;
        end else begin
          err_d   = 1'b1;
          value_d = {h2_q, l_q};
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      cnt_q   <= 4'd0;
      retry_q <= 3'd0;
      h1_q    <= 14'd0;
      l_q     <= 14'd0;
      h2_q    <= 14'd0;
      value_q <= 28'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rchat_q <= 1'b1;
      rchbt_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      h1_q    <= h1_d;
      l_q     <= l_d;
      h2_q    <= h2_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rchat_q <= rchat_d;
      rchbt_q <= rchbt_d;
    end
  end

  assign RCHAT_ = rchat_q;
  assign RCHBT_ = rchbt_q;
  assign VALUE  = value_q;
  assign VALID  = valid_q;
  assign BUSY   = busy_q;
  assign ERR    = err_q;

`ifdef SCALER_READ_DELTA_EN
  logic [27:0] delta_q, delta_d;
  logic        delta_ok_q, delta_ok_d;
  logic        seen_q, seen_d;

  // Difference against the previous VALUE; a retry-exhausted read leaves
  // DELTA untouched and marks it not-ok.
  always_comb begin
    delta_d    = delta_q;
    delta_ok_d = delta_ok_q;
    seen_d     = seen_q;
    if (state_q == S_CHECK && state_d == S_DONE) begin
      seen_d = 1'b1;
      if (halves_match) begin
        delta_d    = {h1_q, l_q} - value_q;
        delta_ok_d = seen_q;
      end else begin
        delta_ok_d = 1'b0;
      end
    end
  end

  // Delta registers.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      delta_q    <= 28'd0;
      delta_ok_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      delta_q    <= delta_d;
      delta_ok_q <= delta_ok_d;
      seen_q     <= seen_d;
    end
  end

  assign DELTA    = delta_q;
  assign DELTA_OK = delta_ok_q;
`endif

endmodule
